spi_slave_param: RTL and testbench

Parametrised successor to the current 8-bit, mode-0-only SPI slave. It supports configurable word width, all four CPOL/CPHA modes, MSB- or LSB-first ordering and full-duplex transmit through a one-word holding register with a valid/ready handshake. Multiple words can be sent per chip-select frame. It sits between an external SPI master and the internal `clk` domain, with all SPI pins oversampled by `clk`.

---
 rtl/spi_slave_param_if.sv | 27 ++
 rtl/spi_slave_param.sv | 202 ++++++++++++++++++++
 tb/tb_spi_slave_param.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_param_if.sv
// SPI pin and word-handshake bundle for spi_slave_param.
`timescale 1ns / 1ps
interface spi_slave_param_if #(
  parameter int unsigned DATA_W = 8
);
  logic              sclk;
  logic              cs;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_underrun;
  logic              busy;

  modport slave (
    input  sclk, cs, mosi, tx_data, tx_valid,
    output miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport master (
    output sclk, cs, mosi, tx_data, tx_valid,
    input  miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
endinterface

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: configurable width, CPOL/CPHA, bit order, one-word
// TX holding register with valid/ready, multiple words per chip-select frame.
// All SPI pins are oversampled in the clk domain.
`timescale 1ns / 1ps
module spi_slave_param #(
  parameter int unsigned DATA_W      = 8,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  spi_slave_param_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic [SYNC_STAGES:0]   prime_q;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               pending_q, pending_d;
  logic               miso_q, miso_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               tx_underrun_q, tx_underrun_d;

  logic sclk_s, cs_s, mosi_s, primed;
  logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, cs_rise;
  logic start_now, drive_now;
  logic [DATA_W-1:0] tx_src, rx_next;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    if (MSB_FIRST) return {w[DATA_W-2:0], 1'b0};
    else           return {1'b0, w[DATA_W-1:1]};
  endfunction

  // Synchronisers, edge-detect history and post-reset priming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= {SYNC_STAGES{CPOL}};
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= CPOL;
      cs_prev_q   <= 1'b1;
      prime_q     <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      prime_q     <= {prime_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  // Until the chains hold real pin values the preset cs=1 could fake a falling
  // edge, so a frame already in progress at reset release is ignored.
  assign primed = prime_q[SYNC_STAGES];

  assign lead_edge   = (sclk_s != sclk_prev_q) && (sclk_prev_q == CPOL);
  assign trail_edge  = (sclk_s != sclk_prev_q) && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = primed && cs_prev_q && !cs_s;
  assign cs_rise     = primed && !cs_prev_q && cs_s;

  assign rx_next = MSB_FIRST ? {rx_shift_q[DATA_W-2:0], mosi_s}
                             : {mosi_s, rx_shift_q[DATA_W-1:1]};

  // Frame FSM, shift datapath and TX holding register next state.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    pending_d     = pending_q;
    miso_d        = miso_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    start_now     = 1'b0;
    drive_now     = 1'b0;
    tx_src        = tx_shift_q;

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d   = StActive;
          start_now = 1'b1;
          // CPHA=0 presents bit 0 immediately; CPHA=1 waits for the leading edge.
          drive_now = !CPHA;
        end
      end
      StActive: begin
        if (cs_rise) begin
          state_d    = StIdle;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          pending_d  = 1'b0;
          miso_d     = 1'b0;
        end else begin
          if (shift_edge) begin
            drive_now = 1'b1;
            start_now = pending_q;
          end
          if (sample_edge) begin
            rx_shift_d = rx_next;
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              bit_cnt_d  = '0;
              rx_data_d  = rx_next;
              rx_valid_d = 1'b1;
              pending_d  = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
    endcase

    if (start_now) begin
      pending_d = 1'b0;
      if (hold_full_q) begin
        tx_src      = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_src        = '0;
        tx_underrun_d = 1'b1;
      end
    end

    if (drive_now) begin
      miso_d     = first_bit(tx_src);
      tx_shift_d = shift_out(tx_src);
    end else if (start_now) begin
      tx_shift_d = tx_src;
    end

    // Acceptance uses the registered ready, so a same-cycle word start still
    // consumes the old content first.
    if (bus.tx_valid && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      pending_q     <= 1'b0;
      miso_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      pending_q     <= pending_d;
      miso_q        <= miso_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign bus.miso        = miso_q && (state_q == StActive);
  assign bus.busy        = (state_q == StActive);
  assign bus.tx_ready    = !hold_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: three configurations share sclk/mosi with
// separate chip selects; received words are checked by a scoreboard.
`timescale 1ns / 1ps
module tb_spi_slave_param;

  localparam int HalfFast = 50;   // 10 MHz sclk
  localparam int HalfSlow = 250;  // 2 MHz sclk

  logic clk, rst_n;
  logic sclk_pin, mosi_pin, cs_a, cs_b, cs_c;

  spi_slave_param_if #(.DATA_W(8))  if_a ();
  spi_slave_param_if #(.DATA_W(8))  if_b ();
  spi_slave_param_if #(.DATA_W(16)) if_c ();

  assign if_a.sclk = sclk_pin;
  assign if_b.sclk = sclk_pin;
  assign if_c.sclk = sclk_pin;
  assign if_a.mosi = mosi_pin;
  assign if_b.mosi = mosi_pin;
  assign if_c.mosi = mosi_pin;
  assign if_a.cs   = cs_a;
  assign if_b.cs   = cs_b;
  assign if_c.cs   = cs_c;

  spi_slave_param u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));

  spi_slave_param #(.CPOL(1'b1), .CPHA(1'b1)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  spi_slave_param #(.DATA_W(16), .MSB_FIRST(1'b0)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int und_a = 0;
  logic [31:0] exp_a[$], exp_b[$], exp_c[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic miso_of(input int sel);
    case (sel)
      0:       return if_a.miso;
      1:       return if_b.miso;
      default: return if_c.miso;
    endcase
  endfunction

  task automatic set_cs(input int sel, input logic v);
    case (sel)
      0:       cs_a = v;
      1:       cs_b = v;
      default: cs_c = v;
    endcase
  endtask

  task automatic cs_low(input int sel, input int half);
    set_cs(sel, 1'b0);
    #(half);
  endtask

  task automatic cs_high(input int sel, input int half);
    #(half);
    set_cs(sel, 1'b1);
    repeat (10) @(negedge clk);
  endtask

  // Master side of one word (or its first nbits bits).
  task automatic xfer(input int sel, input int width, input int nbits, input bit cpol,
                      input bit cpha, input bit msb, input logic [31:0] mo, input int half,
                      output logic [31:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = msb ? width - 1 - i : i;
      if (!cpha) begin
        mosi_pin = mo[idx];
        #(half);
        sclk_pin = ~cpol;
        mi[idx]  = miso_of(sel);
        #(half);
        sclk_pin = cpol;
      end else begin
        sclk_pin = ~cpol;
        mosi_pin = mo[idx];
        #(half);
        sclk_pin = cpol;
        mi[idx]  = miso_of(sel);
        #(half);
      end
    end
  endtask

  task automatic load_tx(input int sel, input logic [31:0] d);
    @(negedge clk);
    case (sel)
      0: begin
        chk("tx_ready_pre_a", 32'(if_a.tx_ready), 1);
        if_a.tx_data = d[7:0]; if_a.tx_valid = 1'b1;
      end
      1: begin
        chk("tx_ready_pre_b", 32'(if_b.tx_ready), 1);
        if_b.tx_data = d[7:0]; if_b.tx_valid = 1'b1;
      end
      default: begin
        chk("tx_ready_pre_c", 32'(if_c.tx_ready), 1);
        if_c.tx_data = d[15:0]; if_c.tx_valid = 1'b1;
      end
    endcase
    @(negedge clk);
    if_a.tx_valid = 1'b0;
    if_b.tx_valid = 1'b0;
    if_c.tx_valid = 1'b0;
    case (sel)
      0:       chk("tx_ready_post_a", 32'(if_a.tx_ready), 0);
      1:       chk("tx_ready_post_b", 32'(if_b.tx_ready), 0);
      default: chk("tx_ready_post_c", 32'(if_c.tx_ready), 0);
    endcase
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_a.size() + exp_b.size() + exp_c.size()) != 0; i++)
      @(negedge clk);
    chk("scoreboard_drained", 32'(exp_a.size() + exp_b.size() + exp_c.size()), 0);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_miso"},     32'(if_a.miso), 0);
    chk({tag, "_rx_data"},  32'(if_a.rx_data), 0);
    chk({tag, "_rx_valid"}, 32'(if_a.rx_valid), 0);
    chk({tag, "_underrun"}, 32'(if_a.tx_underrun), 0);
    chk({tag, "_busy"},     32'(if_a.busy), 0);
    chk({tag, "_tx_ready"}, 32'(if_a.tx_ready), 1);
  endtask

  logic [31:0] mi, mi2;
  int u0, u1, u2;

  initial begin
    rst_n = 1'b0;
    sclk_pin = 1'b0; mosi_pin = 1'b0;
    cs_a = 1'b1; cs_b = 1'b1; cs_c = 1'b1;
    if_a.tx_valid = 1'b0; if_a.tx_data = '0;
    if_b.tx_valid = 1'b0; if_b.tx_data = '0;
    if_c.tx_valid = 1'b0; if_c.tx_data = '0;

    // Scoreboard monitor: pops one expected word per rx_valid cycle.
    fork
      forever begin
        @(negedge clk);
        if (if_a.tx_underrun) und_a++;
        if (if_a.rx_valid) begin
          chk("a_rx_expected", 32'(exp_a.size() != 0), 1);
          if (exp_a.size() != 0) chk("a_rx_data", 32'(if_a.rx_data), exp_a.pop_front());
        end
        if (if_b.rx_valid) begin
          chk("b_rx_expected", 32'(exp_b.size() != 0), 1);
          if (exp_b.size() != 0) chk("b_rx_data", 32'(if_b.rx_data), exp_b.pop_front());
        end
        if (if_c.rx_valid) begin
          chk("c_rx_expected", 32'(exp_c.size() != 0), 1);
          if (exp_c.size() != 0) chk("c_rx_data", 32'(if_c.rx_data), exp_c.pop_front());
        end
      end
    join_none

    #1;
    chk_reset_a("reset");
    chk("reset_c_tx_ready", 32'(if_c.tx_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: mode 0, 8-bit MSB first.
    load_tx(0, 32'h5A);
    exp_a.push_back(32'hA4);
    cs_low(0, HalfFast);
    chk("t1_busy_active", 32'(if_a.busy), 1);
    xfer(0, 8, 8, 1'b0, 1'b0, 1'b1, 32'hA4, HalfFast, mi);
    cs_high(0, HalfFast);
    chk("t1_miso_word", mi, 32'h5A);
    chk("t1_busy_idle", 32'(if_a.busy), 0);
    drain();

    // 2: mode 3; stray sclk edges with cs high must not count.
    sclk_pin = 1'b1;
    #(2 * HalfFast);
    for (int i = 0; i < 3; i++) begin
      sclk_pin = 1'b0; #(HalfFast);
      sclk_pin = 1'b1; #(HalfFast);
    end
    chk("t2_busy_before", 32'(if_b.busy), 0);
    load_tx(1, 32'hC3);
    exp_b.push_back(32'h3C);
    cs_low(1, HalfFast);
    chk("t2_busy_active", 32'(if_b.busy), 1);
    xfer(1, 8, 8, 1'b1, 1'b1, 1'b1, 32'h3C, HalfFast, mi);
    cs_high(1, HalfFast);
    chk("t2_miso_word", mi, 32'hC3);
    sclk_pin = 1'b0;
    repeat (10) @(negedge clk);
    drain();

    // 3: 16-bit LSB first at 2 MHz.
    load_tx(2, 32'h1234);
    exp_c.push_back(32'h8001);
    cs_low(2, HalfSlow);
    xfer(2, 16, 16, 1'b0, 1'b0, 1'b0, 32'h8001, HalfSlow, mi);
    cs_high(2, HalfSlow);
    chk("t3_miso_word", mi, 32'h1234);
    drain();

    // 4: two words in one frame, only one tx word available.
    load_tx(0, 32'h11);
    exp_a.push_back(32'hFF);
    exp_a.push_back(32'h00);
    u0 = und_a;
    cs_low(0, HalfFast);
    chk("t4_tx_ready_after_start", 32'(if_a.tx_ready), 1);
    xfer(0, 8, 8, 1'b0, 1'b0, 1'b1, 32'hFF, HalfFast, mi);
    u1 = und_a;
    xfer(0, 8, 8, 1'b0, 1'b0, 1'b1, 32'h00, HalfFast, mi2);
    u2 = und_a;
    cs_high(0, HalfFast);
    chk("t4_miso_word1", mi, 32'h11);
    chk("t4_miso_word2", mi2, 32'h00);
    chk("t4_underrun_word1", 32'(u1 - u0), 0);
    chk("t4_underrun_word2", 32'(u2 - u1), 1);
    drain();

    // 5: abort after 5 bits, then a full word.
    cs_low(0, HalfFast);
    xfer(0, 8, 5, 1'b0, 1'b0, 1'b1, 32'h80, HalfFast, mi);
    chk("t5_busy_before_abort", 32'(if_a.busy), 1);
    cs_high(0, HalfFast);
    chk("t5_busy_after_abort", 32'(if_a.busy), 0);
    exp_a.push_back(32'h80);
    cs_low(0, HalfFast);
    xfer(0, 8, 8, 1'b0, 1'b0, 1'b1, 32'h80, HalfFast, mi);
    cs_high(0, HalfFast);
    drain();

    // 6: reset mid-word; the open frame must not resume.
    cs_low(0, HalfFast);
    xfer(0, 8, 3, 1'b0, 1'b0, 1'b1, 32'hA5, HalfFast, mi);
    rst_n = 1'b0;
    #1;
    chk_reset_a("t6_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_busy_after_release", 32'(if_a.busy), 0);
    xfer(0, 8, 8, 1'b0, 1'b0, 1'b1, 32'hFF, HalfFast, mi);
    chk("t6_busy_stale_frame", 32'(if_a.busy), 0);
    cs_high(0, HalfFast);
    exp_a.push_back(32'hA5);
    cs_low(0, HalfFast);
    xfer(0, 8, 8, 1'b0, 1'b0, 1'b1, 32'hA5, HalfFast, mi);
    cs_high(0, HalfFast);
    drain();
    chk("t6_rx_data_hold", 32'(if_a.rx_data), 32'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
